// File: rtl/axi_lite_bram_slave.sv
// AXI4-lite slave in front of a word-organised synchronous RAM with byte-strobed writes and SLVERR for out-of-range addresses.
// Latency: RVALID one cycle after the AR handshake; BVALID one cycle after the later of the AW/W handshakes.
// Backpressure: RVALID/BVALID hold until RREADY/BREADY; one read and one write in flight, so the channel readys drop meanwhile.
module axi_lite_bram_slave #(
    parameter int                        MEM_DEPTH        = 4096,
    parameter int                        AXI_ADDR_WIDTH   = 32,
    parameter int                        AXI_DATA_WIDTH   = 32,
    parameter int                        AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8,
    parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE         = '0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [AXI_STROBE_WIDTH-1:0]   S_AXI_WSTRB,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    output logic [1:0]                    S_AXI_BRESP,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Range limits carried one bit wider so a window ending at the top of the address space cannot wrap.
    localparam logic [AXI_ADDR_WIDTH:0] BASE_X  = {1'b0, MEM_BASE};
    localparam logic [AXI_ADDR_WIDTH:0] LIMIT_X = BASE_X + ((AXI_ADDR_WIDTH + 1)'(MEM_DEPTH) << 2);

    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;

    function automatic logic addr_in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH:0] ax;
        ax = {1'b0, a};
        return (ax >= BASE_X) && (ax < LIMIT_X);
    endfunction

    // Byte offsets bits [1:0] are dropped: sub-word addresses hit the containing word.
    function automatic logic [IDX_W-1:0] addr_index(input logic [AXI_ADDR_WIDTH-1:0] a);
        return IDX_W'((a - MEM_BASE) >> 2);
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    rstate_t                     rstate_q, rstate_d;
    wstate_t                     wstate_q, wstate_d;
    logic                        ar_hs;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]                  rresp_q;
    logic [1:0]                  bresp_q;

    logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_STROBE_WIDTH-1:0] wstrb_q, wstrb_d;

    logic                        commit;
    logic [AXI_ADDR_WIDTH-1:0]   commit_addr;
    logic [AXI_DATA_WIDTH-1:0]   commit_data;
    logic [AXI_STROBE_WIDTH-1:0] commit_strb;
    logic                        commit_ok;
    logic                        mem_we;
    logic                        rd_ok;
    logic [IDX_W-1:0]            rd_idx;
    logic [IDX_W-1:0]            wr_idx;

    // PROT carries no meaning for a plain memory endpoint.
    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign rd_ok     = addr_in_range(S_AXI_ARADDR);
    assign rd_idx    = addr_index(S_AXI_ARADDR);
    assign commit_ok = addr_in_range(commit_addr);
    assign wr_idx    = addr_index(commit_addr);
    // A commit coinciding with reset is dropped along with the rest of the transaction.
    assign mem_we    = commit && commit_ok && !RST;

    // Read channel next state; ARREADY is state-decoded so the master can sample it before raising ARVALID.
    always_comb begin
        rstate_d = rstate_q;
        ar_hs    = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    ar_hs    = 1'b1;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Write channel next state and commit selection; the completing handshake picks whichever half is live on the bus.
    always_comb begin
        wstate_d    = wstate_q;
        commit      = 1'b0;
        commit_addr = awaddr_q;
        commit_data = wdata_q;
        commit_strb = wstrb_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        case (wstate_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    commit      = 1'b1;
                    commit_addr = S_AXI_AWADDR;
                    commit_data = S_AXI_WDATA;
                    commit_strb = S_AXI_WSTRB;
                    wstate_d    = W_RESP;
                end else if (S_AXI_AWVALID) begin
                    awaddr_d = S_AXI_AWADDR;
                    wstate_d = W_HAVE_ADDR;
                end else if (S_AXI_WVALID) begin
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                    wstate_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (S_AXI_WVALID) begin
                    commit      = 1'b1;
                    commit_data = S_AXI_WDATA;
                    commit_strb = S_AXI_WSTRB;
                    wstate_d    = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                if (S_AXI_AWVALID) begin
                    commit      = 1'b1;
                    commit_addr = S_AXI_AWADDR;
                    wstate_d    = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // FSM state registers and the registered response fields.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rstate_q <= R_IDLE;
            wstate_q <= W_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            bresp_q  <= RESP_OKAY;
        end else begin
            rstate_q <= rstate_d;
            wstate_q <= wstate_d;
            if (ar_hs) begin
                rdata_q <= rd_ok ? mem[rd_idx] : '0;
                rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (commit) begin
                bresp_q <= commit_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Half-transaction holding registers; stale contents are harmless because the FSM state says whether they are live.
    always_ff @(posedge CLK) begin
        awaddr_q <= awaddr_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
    end

    // RAM byte-lane writes; non-blocking update gives read-first behaviour against a same-cycle read.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < AXI_STROBE_WIDTH; b++) begin
                if (commit_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= commit_data[8*b +: 8];
                end
            end
        end
    end

    assign S_AXI_ARREADY = (rstate_q == R_IDLE);
    assign S_AXI_RVALID  = (rstate_q == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign S_AXI_AWREADY = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_DATA);
    assign S_AXI_WREADY  = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_ADDR);
    assign S_AXI_BVALID  = (wstate_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;

endmodule

// File: tb/tb_axi_lite_bram_slave.sv
// Bench for axi_lite_bram_slave: vector table, cycle-exact corner sequences, randomized traffic against an array model.
// Latency: drives on the falling edge, samples on the falling edge, so every handshake lands on the rising edge between.
// Backpressure: holds RREADY/BREADY low for chosen spans to exercise response stability.
module tb_axi_lite_bram_slave;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        CLK;
    logic        RST;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;

    axi_lite_bram_slave #(
        .MEM_DEPTH      (DEPTH),
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (32),
        .AXI_STROBE_WIDTH(4),
        .MEM_BASE       (BASE)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWPROT (S_AXI_AWPROT),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARPROT (S_AXI_ARPROT),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference memory: a plain word array indexed by byte offset / 4.
    logic [31:0] model_mem [DEPTH];

    function automatic bit model_in_range(input logic [31:0] a);
        longint la, lb;
        la = longint'(a);
        lb = longint'(BASE);
        return (la >= lb) && (la < lb + DEPTH * 4);
    endfunction

    function automatic int model_index(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        int k;
        if (!model_in_range(a)) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            k = model_index(a);
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[k][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        if (!model_in_range(a)) begin
            d = 32'h0;
            resp = 2'b10;
        end else begin
            d = model_mem[model_index(a)];
            resp = 2'b00;
        end
    endtask

    // Full write transaction; AW and W raised after their own delays. Called and returns on a falling edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, output logic [1:0] resp);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        int t = 0;
        S_AXI_AWADDR = a;
        S_AXI_WDATA  = d;
        S_AXI_WSTRB  = s;
        while (!(aw_done && w_done) && t < 40) begin
            S_AXI_AWVALID = !aw_done && (t >= awd);
            S_AXI_WVALID  = !w_done && (t >= wd);
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
            @(negedge CLK);
            t++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) check("write_handshake_timeout", 32'(t), 32'(0));
        check("bvalid_latency", 32'(S_AXI_BVALID), 32'(1));
        t = 0;
        while (!S_AXI_BVALID && t < 40) begin
            @(negedge CLK);
            t++;
        end
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_BREADY = 1'b0;
    endtask

    // Full read transaction with RREADY withheld for rdly cycles after RVALID appears.
    task automatic do_read(input logic [31:0] a, input int rdly, output logic [31:0] d, output logic [1:0] resp);
        int t = 0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && t < 40) begin
            @(negedge CLK);
            t++;
        end
        if (!S_AXI_ARREADY) check("arready_timeout", 32'(S_AXI_ARREADY), 32'(1));
        @(negedge CLK);
        S_AXI_ARVALID = 1'b0;
        check("rvalid_latency", 32'(S_AXI_RVALID), 32'(1));
        repeat (rdly) @(negedge CLK);
        d    = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(negedge CLK);
        S_AXI_RREADY = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] rd, exp_d, a, d;
    logic [1:0]  rr, br, exp_r;
    logic [3:0]  s;

    initial begin
        tbl[0] = '{32'h0000_1010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hDEAD_BEEF, 2'b00};
        tbl[1] = '{32'h0000_1020, 32'h1122_3344, 4'hF, 2'b00, 32'h1122_3344, 2'b00};
        tbl[2] = '{32'h0000_1020, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h11BB_33DD, 2'b00};
        tbl[3] = '{32'h0000_1023, 32'h0000_0000, 4'h8, 2'b00, 32'h00BB_33DD, 2'b00};
        tbl[4] = '{32'h0000_1000, 32'h0102_0304, 4'hF, 2'b00, 32'h0102_0304, 2'b00};
        tbl[5] = '{32'h0000_10FC, 32'hCAFE_F00D, 4'hF, 2'b00, 32'hCAFE_F00D, 2'b00};
        tbl[6] = '{32'h0000_1000, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0102_0304, 2'b00};
        tbl[7] = '{32'h0000_1100, 32'h1234_5678, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
        tbl[8] = '{32'h0000_0FFC, 32'h8765_4321, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
        tbl[9] = '{32'h0000_10FE, 32'hAA00_0000, 4'h8, 2'b00, 32'hAAFE_F00D, 2'b00};

        RST = 1'b1;
        S_AXI_AWVALID = 1'b0; S_AXI_AWADDR = '0; S_AXI_AWPROT = 3'b000;
        S_AXI_WVALID  = 1'b0; S_AXI_WDATA  = '0; S_AXI_WSTRB  = 4'h0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARVALID = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'b000;
        S_AXI_RREADY  = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // Reset state of every output.
        check("rst_awready", 32'(S_AXI_AWREADY), 32'(1));
        check("rst_wready",  32'(S_AXI_WREADY),  32'(1));
        check("rst_arready", 32'(S_AXI_ARREADY), 32'(1));
        check("rst_bvalid",  32'(S_AXI_BVALID),  32'(0));
        check("rst_rvalid",  32'(S_AXI_RVALID),  32'(0));
        check("rst_bresp",   32'(S_AXI_BRESP),   32'(0));
        check("rst_rresp",   32'(S_AXI_RRESP),   32'(0));
        check("rst_rdata",   S_AXI_RDATA,        32'h0);

        // Give every word a known random value so the model covers all of RAM.
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            model_write(BASE + 32'(i * 4), d, 4'hF, exp_r);
            do_write(BASE + 32'(i * 4), d, 4'hF, 0, 0, br);
            check("init_bresp", 32'(br), 32'(exp_r));
        end

        // Vector table: write, then read the same address back.
        for (int i = 0; i < 10; i++) begin
            do_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, 0, 0, br);
            model_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, exp_r);
            check($sformatf("tbl%0d_bresp", i), 32'(br), 32'(tbl[i].bresp));
            do_read(tbl[i].addr, 0, rd, rr);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
            check($sformatf("tbl%0d_rresp", i), 32'(rr), 32'(tbl[i].rresp));
        end
        // Out-of-range writes must not have aliased onto the first or last word.
        do_read(32'h0000_1000, 0, rd, rr);
        check("oor_word0_intact", rd, 32'h0102_0304);
        do_read(32'h0000_10FC, 0, rd, rr);
        check("oor_last_intact", rd, 32'hAAFE_F00D);

        // Same-cycle AW+W, BVALID next cycle, then BREADY held low for 5 cycles.
        S_AXI_AWADDR = 32'h0000_1040; S_AXI_WDATA = 32'h55AA_55AA; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        model_write(32'h0000_1040, 32'h55AA_55AA, 4'hF, exp_r);
        check("w_bvalid_n1", 32'(S_AXI_BVALID), 32'(1));
        check("w_bresp_n1",  32'(S_AXI_BRESP),  32'(0));
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid",  32'(S_AXI_BVALID),  32'(1));
            check("bp_awready", 32'(S_AXI_AWREADY), 32'(0));
            check("bp_wready",  32'(S_AXI_WREADY),  32'(0));
            @(negedge CLK);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_BREADY = 1'b0;
        check("b_done_bvalid",  32'(S_AXI_BVALID),  32'(0));
        check("b_done_awready", 32'(S_AXI_AWREADY), 32'(1));

        // Read with RREADY held low for 5 cycles.
        S_AXI_ARADDR = 32'h0000_1040; S_AXI_ARVALID = 1'b1;
        @(negedge CLK);
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rbp_rvalid",  32'(S_AXI_RVALID),  32'(1));
            check("rbp_rdata",   S_AXI_RDATA,        32'h55AA_55AA);
            check("rbp_arready", 32'(S_AXI_ARREADY), 32'(0));
            @(negedge CLK);
        end
        S_AXI_RREADY = 1'b1;
        @(negedge CLK);
        S_AXI_RREADY = 1'b0;
        check("r_done_rvalid",  32'(S_AXI_RVALID),  32'(0));
        check("r_done_arready", 32'(S_AXI_ARREADY), 32'(1));

        // Split: W at cycle 0, AW at cycle 3, BVALID at cycle 4.
        S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(negedge CLK);
        S_AXI_WVALID = 1'b0;
        for (int i = 1; i < 3; i++) begin
            check("wfirst_awready", 32'(S_AXI_AWREADY), 32'(1));
            check("wfirst_wready",  32'(S_AXI_WREADY),  32'(0));
            check("wfirst_bvalid",  32'(S_AXI_BVALID),  32'(0));
            @(negedge CLK);
        end
        S_AXI_AWADDR = 32'h0000_1044; S_AXI_AWVALID = 1'b1;
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0;
        check("wfirst_bvalid_c4", 32'(S_AXI_BVALID), 32'(1));
        S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_BREADY = 1'b0;
        model_write(32'h0000_1044, 32'h0BAD_F00D, 4'hF, exp_r);
        do_read(32'h0000_1044, 0, rd, rr);
        check("wfirst_data", rd, 32'h0BAD_F00D);

        // Split: AW at cycle 0, W at cycle 3.
        S_AXI_AWADDR = 32'h0000_1048; S_AXI_AWVALID = 1'b1;
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0;
        for (int i = 1; i < 3; i++) begin
            check("afirst_awready", 32'(S_AXI_AWREADY), 32'(0));
            check("afirst_wready",  32'(S_AXI_WREADY),  32'(1));
            check("afirst_bvalid",  32'(S_AXI_BVALID),  32'(0));
            @(negedge CLK);
        end
        S_AXI_WDATA = 32'h600D_CAFE; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(negedge CLK);
        S_AXI_WVALID = 1'b0;
        check("afirst_bvalid_c4", 32'(S_AXI_BVALID), 32'(1));
        S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_BREADY = 1'b0;
        model_write(32'h0000_1048, 32'h600D_CAFE, 4'hF, exp_r);
        do_read(32'h0000_1048, 0, rd, rr);
        check("afirst_data", rd, 32'h600D_CAFE);

        // Same-cycle read and write of word 5: read returns the old value.
        do_write(32'h0000_1014, 32'h1111_1111, 4'hF, 0, 0, br);
        S_AXI_ARADDR = 32'h0000_1014; S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR = 32'h0000_1014; S_AXI_WDATA = 32'h2222_2222; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(negedge CLK);
        S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("rfirst_rdata",  S_AXI_RDATA,        32'h1111_1111);
        check("rfirst_bvalid", 32'(S_AXI_BVALID),  32'(1));
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
        model_write(32'h0000_1014, 32'h2222_2222, 4'hF, exp_r);
        do_read(32'h0000_1014, 0, rd, rr);
        check("rfirst_newdata", rd, 32'h2222_2222);

        // Reset while holding an address: transaction dropped, later W alone must not commit.
        S_AXI_AWADDR = 32'h0000_1018; S_AXI_AWVALID = 1'b1;
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0;
        check("haveaddr_awready", 32'(S_AXI_AWREADY), 32'(0));
        check("haveaddr_wready",  32'(S_AXI_WREADY),  32'(1));
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_awready", 32'(S_AXI_AWREADY), 32'(1));
        check("midrst_wready",  32'(S_AXI_WREADY),  32'(1));
        check("midrst_bvalid",  32'(S_AXI_BVALID),  32'(0));
        S_AXI_WDATA = 32'hBAD0_BAD0; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(negedge CLK);
        S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("midrst_no_commit_bvalid", 32'(S_AXI_BVALID), 32'(0));
            check("midrst_havedata_wready",  32'(S_AXI_WREADY),  32'(0));
            @(negedge CLK);
        end
        S_AXI_AWADDR = 32'h0000_101C; S_AXI_AWVALID = 1'b1;
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0;
        check("midrst_late_bvalid", 32'(S_AXI_BVALID), 32'(1));
        S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_BREADY = 1'b0;
        model_write(32'h0000_101C, 32'hBAD0_BAD0, 4'hF, exp_r);
        model_read(32'h0000_1018, exp_d, exp_r);
        do_read(32'h0000_1018, 0, rd, rr);
        check("midrst_word_intact", rd, exp_d);
        do_read(32'h0000_101C, 0, rd, rr);
        check("midrst_late_data", rd, 32'hBAD0_BAD0);

        // Randomized traffic against the model.
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 9))
                8:       a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 63) * 4);
                9:       a = BASE - 32'd4 - 32'($urandom_range(0, 63) * 4);
                default: a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                model_write(a, d, s, exp_r);
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), br);
                check("rand_bresp", 32'(br), 32'(exp_r));
            end else begin
                model_read(a, exp_d, exp_r);
                do_read(a, $urandom_range(0, 2), rd, rr);
                check("rand_rdata", rd, exp_d);
                check("rand_rresp", 32'(rr), 32'(exp_r));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
